// File: rtl/lenet_pkg.sv
// Shared constants, FSM state encoding and width helper for the LeNet argmax classifier.
package lenet_pkg;

  localparam int NUM_CLASSES = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic int score_w(input int bitwidth);
    return bitwidth + 8;
  endfunction

endpackage

// File: rtl/lenet_argmax_step.sv
// One comparison step of the running top-1/top-2 search.
// Strict compares keep the lowest index on ties; an equal value still raises the runner-up.
module lenet_argmax_step #(
  parameter int W  = 17,
  parameter int IW = 4
) (
  input  logic signed [W-1:0]  best_i,
  input  logic        [IW-1:0] best_idx_i,
  input  logic signed [W-1:0]  second_i,
  input  logic signed [W-1:0]  cand_i,
  input  logic        [IW-1:0] cand_idx_i,
  output logic signed [W-1:0]  best_o,
  output logic        [IW-1:0] best_idx_o,
  output logic signed [W-1:0]  second_o
);

  always_comb begin
    best_o     = best_i;
    best_idx_o = best_idx_i;
    second_o   = second_i;
    if (cand_i > best_i) begin
      second_o   = best_i;
      best_o     = cand_i;
      best_idx_o = cand_idx_i;
    end else if (cand_i > second_i) begin
      second_o = cand_i;
    end
  end

endmodule

// File: rtl/lenet_argmax_classifier.sv
// Captures a score vector, scans it one class per cycle and holds the argmax,
// its score and the top-1/top-2 margin until the consumer accepts them.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and a held result stays stable until taken.
module lenet_argmax_classifier
  import lenet_pkg::*;
#(
  parameter int BITWIDTH    = 9,
  parameter int NUM_CLASSES = lenet_pkg::NUM_CLASSES,
  localparam int SCORE_W    = score_w(BITWIDTH),
  localparam int IDX_W      = $clog2(NUM_CLASSES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [SCORE_W-1:0] scores [NUM_CLASSES-1:0],
  input  logic                      scores_valid,
  output logic                      scores_ready,
  output logic        [IDX_W-1:0]   class_idx,
  output logic signed [SCORE_W-1:0] max_score,
  output logic        [SCORE_W:0]   margin,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic                      busy
);

  localparam logic signed [SCORE_W-1:0] MOST_NEG = {1'b1, {(SCORE_W-1){1'b0}}};

  state_t state_q, state_d;

  logic signed [SCORE_W-1:0] bank_q [NUM_CLASSES-1:0];
  logic signed [SCORE_W-1:0] best_q, second_q;
  logic        [IDX_W-1:0]   best_idx_q, idx_q;
  logic        [IDX_W-1:0]   class_idx_q;
  logic signed [SCORE_W-1:0] max_score_q;
  logic        [SCORE_W:0]   margin_q;

  logic signed [SCORE_W-1:0] best_d, second_d;
  logic        [IDX_W-1:0]   best_idx_d;
  logic signed [SCORE_W:0]   margin_d;
  logic                      accept;
  logic                      last_step;

  assign scores_ready = (state_q == IDLE) && !rst;
  assign accept       = scores_valid && scores_ready;
  assign last_step    = (idx_q == IDX_W'(NUM_CLASSES - 1));
  assign result_valid = (state_q == HOLD);
  assign busy         = (state_q != IDLE);

  assign class_idx = class_idx_q;
  assign max_score = max_score_q;
  assign margin    = margin_q;

  lenet_argmax_step #(
    .W  (SCORE_W),
    .IW (IDX_W)
  ) u_step (
    .best_i     (best_q),
    .best_idx_i (best_idx_q),
    .second_i   (second_q),
    .cand_i     (bank_q[idx_q]),
    .cand_idx_i (idx_q),
    .best_o     (best_d),
    .best_idx_o (best_idx_d),
    .second_o   (second_d)
  );

  // One extra bit keeps best - second non-negative across the full signed range.
  assign margin_d = {best_d[SCORE_W-1], best_d} - {second_d[SCORE_W-1], second_d};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SCAN;
      SCAN:    if (last_step) state_d = HOLD;
      HOLD:    if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_CLASSES; i++) bank_q[i] <= scores[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      best_q      <= '0;
      best_idx_q  <= '0;
      second_q    <= '0;
      idx_q       <= '0;
      class_idx_q <= '0;
      max_score_q <= '0;
      margin_q    <= '0;
    end else if (accept) begin
      best_q     <= scores[0];
      best_idx_q <= '0;
      second_q   <= MOST_NEG;
      idx_q      <= IDX_W'(1);
    end else if (state_q == SCAN) begin
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      second_q   <= second_d;
      idx_q      <= idx_q + IDX_W'(1);
      if (last_step) begin
        class_idx_q <= best_idx_d;
        max_score_q <= best_d;
        margin_q    <= margin_d;
      end
    end
  end

endmodule

// File: tb/tb_lenet_argmax_classifier.sv
// Directed bench for lenet_argmax_classifier with an argmax reference model and scoreboard.
module tb_lenet_argmax_classifier;

  localparam int NC = 10;
  localparam int SW = 17;
  localparam int IW = 4;
  localparam int MW = SW + 1;
  localparam int RW = IW + SW + MW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic signed [SW-1:0] scores [NC-1:0];
  logic                 scores_valid = 1'b0;
  logic                 scores_ready;
  logic [IW-1:0]        class_idx;
  logic signed [SW-1:0] max_score;
  logic [MW-1:0]        margin;
  logic                 result_valid;
  logic                 result_ready = 1'b0;
  logic                 busy;

  lenet_argmax_classifier dut (
    .clk          (clk),
    .rst          (rst),
    .scores       (scores),
    .scores_valid (scores_valid),
    .scores_ready (scores_ready),
    .class_idx    (class_idx),
    .max_score    (max_score),
    .margin       (margin),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [RW-1:0] exp_q[$];
  int acc_log[$];
  int tmp_s[NC];
  logic prev_rv = 1'b0;

  int v1[NC], v_tie[NC], v_ext[NC], v_neg[NC];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Argmax = first index holding the maximum; runner-up = largest of the remaining entries.
  function automatic logic [RW-1:0] model(input int s[NC]);
    int bi, bv, sv, mg;
    logic [IW-1:0] ri;
    logic [SW-1:0] rv;
    logic [MW-1:0] rm;
    bv = s[0];
    for (int i = 1; i < NC; i++) if (s[i] > bv) bv = s[i];
    bi = 0;
    for (int i = NC - 1; i >= 0; i--) if (s[i] == bv) bi = i;
    sv = (bi == 0) ? s[1] : s[0];
    for (int j = 0; j < NC; j++) if (j != bi && s[j] > sv) sv = s[j];
    mg = bv - sv;
    ri = bi[IW-1:0];
    rv = bv[SW-1:0];
    rm = mg[MW-1:0];
    return {ri, rv, rm};
  endfunction

  // scoreboard: push on accept, compare every cycle a result is presented
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_rv <= 1'b0;
    end else begin
      if (scores_valid && scores_ready) begin
        for (int i = 0; i < NC; i++) tmp_s[i] = int'(scores[i]);
        exp_q.push_back(model(tmp_s));
        acc_log.push_back(cyc + 1);
      end
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got result_valid=1 required no pending result");
        end else begin
          check("result", {class_idx, max_score, margin}, exp_q[0]);
          if (!prev_rv && acc_log.size() > 0) check("latency", cyc - acc_log[$], 9);
          if (result_ready) void'(exp_q.pop_front());
        end
      end
      prev_rv <= result_valid;
    end
  end

  // driver tasks
  task automatic load(input int v[NC]);
    for (int i = 0; i < NC; i++) scores[i] = SW'(v[i]);
  endtask

  task automatic send(input int v[NC]);
    int n = 0;
    @(posedge clk);
    #1;
    load(v);
    scores_valid = 1'b1;
    @(negedge clk);
    while (!scores_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got scores_ready=0 required 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    scores_valid = 1'b0;
  endtask

  task automatic wait_result();
    int n = 0;
    @(negedge clk);
    while (!result_valid && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (!result_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL result_timeout: got result_valid=0 required 1 within 60 cycles");
    end
  endtask

  task automatic check_out(input string tag, input int idx, input int mx, input int mg);
    check({tag, "_class"}, class_idx, 64'(idx));
    check({tag, "_max"}, max_score, 64'(mx));
    check({tag, "_margin"}, margin, 64'(mg));
  endtask

  initial begin
    for (int i = 0; i < NC; i++) scores[i] = '0;
    v1 = '{5, -3, 100, 7, 0, 2, -50, 99, 1, 4};
    for (int i = 0; i < NC; i++) begin
      v_tie[i] = 0;
      v_ext[i] = -65536;
      v_neg[i] = -65536;
    end
    v_tie[3] = 42;
    v_tie[8] = 42;
    v_ext[6] = 65535;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_scores_ready", scores_ready, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    check_out("rst", 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_scores_ready", scores_ready, 1);

    // pin the model with hand-computed results
    check("model_v1", model(v1), {4'd2, 17'd100, 18'd1});
    check("model_tie", model(v_tie), {4'd3, 17'd42, 18'd0});
    check("model_ext", model(v_ext), {4'd6, 17'h0FFFF, 18'h1FFFF});
    check("model_neg", model(v_neg), {4'd0, 17'h10000, 18'd0});

    // distinct max
    @(posedge clk);
    #1 result_ready = 1'b1;
    send(v1);
    wait_result();
    check_out("v1", 2, 100, 1);

    // back-pressure with ignored second vector
    @(posedge clk);
    #1 result_ready = 1'b0;
    send(v_tie);
    wait_result();
    check_out("tie", 3, 42, 0);
    @(posedge clk);
    #1;
    load(v1);
    scores_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("bp_scores_ready", scores_ready, 0);
      check("bp_result_valid", result_valid, 1);
      check_out("bp", 3, 42, 0);
    end
    @(posedge clk);
    #1;
    scores_valid = 1'b0;
    result_ready = 1'b1;
    @(posedge clk);
    #1 result_ready = 1'b0;
    @(negedge clk);
    check("bp_release_valid", result_valid, 0);
    check("bp_release_ready", scores_ready, 1);

    // reset mid-SCAN, then a fresh vector
    @(posedge clk);
    #1 result_ready = 1'b1;
    send(v1);
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_result_valid", result_valid, 0);
    check_out("midrst", 0, 0, 0);
    send(v_ext);
    wait_result();
    check_out("ext", 6, 65535, 131071);
    send(v_neg);
    wait_result();
    check_out("neg", 0, -65536, 0);

    // back-to-back with result_ready tied high
    send(v1);
    send(v_tie);
    wait_result();
    check_out("b2b", 3, 42, 0);
    if (acc_log.size() >= 2) check("b2b_spacing", acc_log[$] - acc_log[$-1], 11);
    else check("b2b_accepts", acc_log.size(), 2);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
